// File: rtl/s4ga_array.sv
// s4ga_array: streamed-configuration LUT array; each frame carries K input indices and a 2**K-bit mask.
// Optional macro S4GA_SYNC_EN selects two-phase evaluation (committed copy swapped once per sweep).
module s4ga_array #(
  parameter int unsigned N     = 16,
  parameter int unsigned K     = 4,
  parameter int unsigned SI_W  = 4,
  parameter int unsigned OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 si_valid,
  input  logic [SI_W-1:0]      si,
  output logic [OUT_W-1:0]     out,
  output logic [$clog2(N)-1:0] lut_idx,
  output logic                 sweep_done
);

  localparam int unsigned N_W       = $clog2(N);
  localparam int unsigned IDX_SPAN  = 1 << N_W;
  localparam int unsigned IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int unsigned MASK_W    = 1 << K;
  localparam int unsigned MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int unsigned MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int unsigned SEG_W     = $clog2(MAX_SEGS) + 1;
  localparam int unsigned K_W       = $clog2(K + 1);
  localparam int unsigned SR_W      = (MAX_SEGS > 1) ? (MAX_SEGS - 1) * SI_W : SI_W;
  localparam int unsigned CAT_W     = SR_W + SI_W;

  logic [SR_W-1:0]     sr_q, sr_d;
  logic [K-1:0]        ins_q, ins_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [N-1:0]        luts_q, luts_d;
  logic                done_q, done_d;
`ifdef S4GA_SYNC_EN
  logic [N-1:0]        cur_q, cur_d;
`endif

  logic [CAT_W-1:0]    cat;
  logic [N_W-1:0]      idx;
  logic [MASK_W-1:0]   mask;
  logic [N-1:0]        state;
  logic [IDX_SPAN-1:0] state_ext;
  logic                in_bit;
  logic                wr_bit;
  logic                idx_phase;
  logic                last_seg;
  logic                last_lut;

  // Field assembled from earlier beats plus the current one, MSB-first.
  assign cat  = {sr_q, si};
  assign idx  = cat[N_W-1:0];
  assign mask = cat[MASK_W-1:0];

`ifdef S4GA_SYNC_EN
  assign state = cur_q;
  assign out   = cur_q[OUT_W-1:0];
`else
  assign state = luts_q;
  assign out   = luts_q[OUT_W-1:0];
`endif

  // Indices beyond N-1 land in the zero padding and read as 0.
  always_comb begin
    state_ext        = '0;
    state_ext[N-1:0] = state;
  end

  assign in_bit     = state_ext[idx];
  assign wr_bit     = mask[ins_q];
  assign idx_phase  = (k_q != K_W'(K));
  assign last_seg   = idx_phase ? (seg_q == SEG_W'(IDX_SEGS - 1))
                                : (seg_q == SEG_W'(MASK_SEGS - 1));
  assign last_lut   = (n_q == N_W'(N - 1));
  assign lut_idx    = n_q;
  assign sweep_done = done_q;

  always_comb begin
    sr_d   = sr_q;
    ins_d  = ins_q;
    n_d    = n_q;
    k_d    = k_q;
    seg_d  = seg_q;
    luts_d = luts_q;
    done_d = 1'b0;
`ifdef S4GA_SYNC_EN
    cur_d  = cur_q;
`endif
    if (si_valid) begin
      sr_d = cat[SR_W-1:0];
      if (!last_seg) begin
        seg_d = seg_q + SEG_W'(1);
      end else begin
        seg_d = '0;
        if (idx_phase) begin
          ins_d = K'({ins_q, in_bit});
          k_d   = k_q + K_W'(1);
        end else begin
          k_d          = '0;
          luts_d[n_q]  = wr_bit;
          n_d          = last_lut ? '0 : n_q + N_W'(1);
          done_d       = last_lut;
`ifdef S4GA_SYNC_EN
          // Commit the whole sweep, including the LUT written this edge.
          if (last_lut) cur_d = luts_d;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      ins_q  <= '0;
      n_q    <= '0;
      k_q    <= '0;
      seg_q  <= '0;
      luts_q <= '0;
      done_q <= 1'b0;
`ifdef S4GA_SYNC_EN
      cur_q  <= '0;
`endif
    end else begin
      sr_q   <= sr_d;
      ins_q  <= ins_d;
      n_q    <= n_d;
      k_q    <= k_d;
      seg_q  <= seg_d;
      luts_q <= luts_d;
      done_q <= done_d;
`ifdef S4GA_SYNC_EN
      cur_q  <= cur_d;
`endif
    end
  end

endmodule

// File: tb/tb_s4ga_array.sv
// Bench for s4ga_array: frame-level reference model, table of constant sweeps, ring/reset/out-of-range sequences.
module tb_s4ga_array;

  localparam int unsigned N         = 16;
  localparam int unsigned K         = 4;
  localparam int unsigned SI_W      = 4;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned N_W       = $clog2(N);
  localparam int unsigned IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int unsigned MASK_W    = 1 << K;
  localparam int unsigned MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;

  typedef logic [K-1:0][N_W-1:0] idxs_t;
  typedef struct {
    logic [N_W-1:0]    idx;
    logic [MASK_W-1:0] mask;
    bit                stall;
    logic [OUT_W-1:0]  want;
  } vec_t;

  logic                clk;
  logic                rst;
  logic                si_valid;
  logic [SI_W-1:0]     si;
  logic [OUT_W-1:0]    out;
  logic [N_W-1:0]      lut_idx;
  logic                sweep_done;
  logic [OUT_W-1:0]    out13;
  logic [3:0]          lut_idx13;
  logic                sweep_done13;

  s4ga_array #(.N(N), .K(K), .SI_W(SI_W), .OUT_W(OUT_W)) u_dut (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si(si),
    .out(out), .lut_idx(lut_idx), .sweep_done(sweep_done)
  );

  s4ga_array #(.N(13), .K(K), .SI_W(SI_W), .OUT_W(OUT_W)) u_dut13 (
    .clk(clk), .rst(rst), .si_valid(si_valid), .si(si),
    .out(out13), .lut_idx(lut_idx13), .sweep_done(sweep_done13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_luts is the written copy, m_cur the committed copy (two-phase only).
  bit m_luts[N];
  bit m_cur[N];
  int m_n;
  bit m_sd;
  int vec_cnt;
  int err_cnt;
  logic [SI_W-1:0] beat_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_luts[i] = 1'b0;
      m_cur[i]  = 1'b0;
    end
    m_n  = 0;
    m_sd = 1'b0;
  endfunction

  function automatic logic [OUT_W-1:0] exp_out();
    logic [OUT_W-1:0] v;
    for (int i = 0; i < OUT_W; i++) begin
`ifdef S4GA_SYNC_EN
      v[i] = m_cur[i];
`else
      v[i] = m_luts[i];
`endif
    end
    return v;
  endfunction

  function automatic void model_frame(input idxs_t idxs, input logic [MASK_W-1:0] mask);
    int unsigned ins;
    int unsigned ix;
    bit b;
    ins = 0;
    for (int j = 0; j < K; j++) begin
      ix = int'(idxs[j]);
`ifdef S4GA_SYNC_EN
      b = (ix < N) ? m_cur[ix] : 1'b0;
`else
      b = (ix < N) ? m_luts[ix] : 1'b0;
`endif
      ins = ins * 2 + int'(b);
    end
    m_luts[m_n] = mask[ins];
`ifdef S4GA_SYNC_EN
    if (m_n == N - 1)
      for (int i = 0; i < N; i++) m_cur[i] = m_luts[i];
`endif
    m_sd = (m_n == N - 1);
    m_n  = (m_n + 1) % N;
  endfunction

  function automatic void push_field(input logic [63:0] val, input int fw, input int segs);
    logic [63:0] w;
    w = {$urandom, $urandom};
    for (int b = 0; b < fw; b++) w[b] = val[b];
    for (int s = segs - 1; s >= 0; s--) beat_q.push_back(w[s*SI_W +: SI_W]);
  endfunction

  function automatic idxs_t all_idx(input int unsigned v);
    idxs_t r;
    for (int j = 0; j < K; j++) r[j] = N_W'(v);
    return r;
  endfunction

  task automatic apply(input bit v, input logic [SI_W-1:0] d);
    si_valid = v;
    si       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    cmp("out", 32'(out), 32'(exp_out()));
    cmp("lut_idx", 32'(lut_idx), 32'(m_n));
    cmp("sweep_done", 32'(sweep_done), 32'(m_sd));
  endtask

  // Sends one frame (optionally only its first stop_after beats); stall inserts an idle cycle before each beat.
  task automatic do_frame(input idxs_t idxs, input logic [MASK_W-1:0] mask, input bit stall,
                          input int stop_after);
    beat_q.delete();
    for (int j = 0; j < K; j++) push_field(64'(idxs[j]), N_W, IDX_SEGS);
    push_field(64'(mask), MASK_W, MASK_SEGS);
    for (int b = 0; b < beat_q.size() && b < stop_after; b++) begin
      if (stall) begin
        m_sd = 1'b0;
        apply(1'b0, SI_W'($urandom));
        check_all();
      end
      apply(1'b1, beat_q[b]);
      if (b == beat_q.size() - 1) model_frame(idxs, mask);
      else m_sd = 1'b0;
      check_all();
    end
  endtask

  task automatic ring_frame(input int n, input int stop_after);
    logic [MASK_W-1:0] buf_mask;
    buf_mask = '0;
    buf_mask[MASK_W-1] = 1'b1;
    if (n == 0) do_frame(all_idx(15), MASK_W'(1), 1'b0, stop_after);
    else        do_frame(all_idx(n - 1), buf_mask, 1'b0, stop_after);
  endtask

  task automatic const_sweep(input int unsigned ix, input logic [MASK_W-1:0] mask, input bit stall);
    for (int n = 0; n < N; n++) do_frame(all_idx(ix), mask, stall, 1000);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) apply(1'b1, 4'hF);
    rst = 1'b0;
    model_reset();
    cmp("rst_out", 32'(out), 32'h0);
    cmp("rst_lut_idx", 32'(lut_idx), 32'h0);
    cmp("rst_sweep_done", 32'(sweep_done), 32'h0);
    cmp("rst_out13", 32'(out13), 32'h0);
  endtask

  initial begin
    vec_t             tbl[5];
    logic [OUT_W-1:0] ring_exp[3];
    logic [OUT_W-1:0] ring13_exp;
    idxs_t            ridx;

    tbl[0] = '{idx: 4'd0,  mask: 16'hFFFF, stall: 1'b0, want: 8'hFF};
    tbl[1] = '{idx: 4'd0,  mask: 16'h0000, stall: 1'b1, want: 8'h00};
    tbl[2] = '{idx: 4'd15, mask: 16'h0001, stall: 1'b0, want: 8'hFF};
    tbl[3] = '{idx: 4'd15, mask: 16'h0001, stall: 1'b1, want: 8'h00};
    tbl[4] = '{idx: 4'd0,  mask: 16'hFFFF, stall: 1'b1, want: 8'hFF};
`ifdef S4GA_SYNC_EN
    ring_exp   = '{8'h01, 8'h03, 8'h07};
    ring13_exp = 8'h01;
`else
    ring_exp   = '{8'hFF, 8'h00, 8'hFF};
    ring13_exp = 8'hFF;
`endif

    vec_cnt  = 0;
    err_cnt  = 0;
    rst      = 1'b1;
    si_valid = 1'b0;
    si       = '0;
    model_reset();

    do_reset(2);

    // Ring oscillator over three sweeps; the N=13 instance sees the same stream.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < N; n++) begin
        ring_frame(n, 1000);
        if (s == 0 && n == 12) begin
          cmp("n13_out", 32'(out13), 32'(ring13_exp));
          cmp("n13_lut0", 32'(out13[0]), 32'h1);
          cmp("n13_lut_idx", 32'(lut_idx13), 32'h0);
          cmp("n13_sweep_done", 32'(sweep_done13), 32'h1);
        end
      end
      cmp("ring_sweep", 32'(out), 32'(ring_exp[s]));
    end

    // Reset in the middle of LUT 3's frame, then a clean constant-one sweep.
    for (int n = 0; n < 3; n++) ring_frame(n, 1000);
    ring_frame(3, 5);
    cmp("mid_lut_idx", 32'(lut_idx), 32'h3);
    do_reset(1);
    const_sweep(0, 16'hFFFF, 1'b0);
    cmp("clean_sweep_out", 32'(out), 32'hFF);
    cmp("clean_sweep_idx", 32'(lut_idx), 32'h0);

    for (int i = 0; i < 5; i++) begin
      const_sweep(int'(tbl[i].idx), tbl[i].mask, tbl[i].stall);
      cmp("tbl_out", 32'(out), 32'(tbl[i].want));
      cmp("tbl_lut_idx", 32'(lut_idx), 32'h0);
    end

    // Random frames with random stalls against the model.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < N; n++) begin
        for (int j = 0; j < K; j++) ridx[j] = N_W'($urandom);
        do_frame(ridx, MASK_W'($urandom), 1'($urandom_range(0, 1)), 1000);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/s4ga_array.md
# s4ga_array

Streamed-configuration LUT array: consumes a serial stream of LUT configuration frames (K input indices plus a 2**K-bit mask per LUT), SI_W bits per accepted beat, and evaluates each LUT as its frame completes. Successor to the fixed-rate s4ga core: adds a valid handshake (stall-tolerant stream), direct-addressed LUT state, range-safe input indices, sweep-completion signalling and an optional synchronous (two-phase) evaluation mode. Sits between the tile's config/stream pins and the user I/O mux.

## Interface
- N, 16: number of LUTs (N >= 2).
- K, 4: inputs per LUT (1..6).
- SI_W, 4: stream beat width in bits.
- OUT_W, 8: number of LUT outputs exported (OUT_W <= N).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high; overrides all other inputs.
- si_valid  in  1  beat qualifier; beat on si accepted on a clock edge where si_valid=1 and rst=0.
- si  in  SI_W  configuration beat.
- out  out  OUT_W  committed values of LUTs 0..OUT_W-1 (out[i] = LUT i).
- lut_idx  out  clog2(N)  index n of LUT whose frame is currently being received.
- sweep_done  out  1  one-cycle pulse after LUT N-1 is evaluated.

## Operation
- Derived: N_W = clog2(N); IDX_SEGS = ceil(N_W/SI_W); MASK_W = 2**K; MASK_SEGS = ceil(MASK_W/SI_W).
- Frame per LUT: K index fields (IDX_SEGS beats each), then mask (MASK_SEGS beats). Every field sent MSB-first; padding bits occupy the top of the field's first beat and are discarded.
- State: n in [0,N), k in [0,K], seg; k<K = IDX phase, k==K = MASK phase. Counters and the beat shift register sr advance only on accepted beats.
- IDX phase, final beat: idx = low N_W bits of {sr,si}; in = (idx < N) ? state[idx] : 0; ins <= {ins,in}; k++, seg=0. Index 0 of the frame becomes MSB of ins.
- MASK phase, final beat: mask = low MASK_W bits of {sr,si}; luts[n] <= mask[ins]; k=0, seg=0; n <= (n==N-1) ? 0 : n+1.
- state[] is luts (in-place mode) or the committed copy (see Configuration).
- An index naming LUT n itself reads its value before this frame's write.
- sweep_done registered: high for exactly the cycle after the edge that writes LUT N-1.
- si_valid=0: no counter, sr, ins, luts or output change; sweep_done still falls.

## Timing
- Reset values: out=0, lut_idx=0, sweep_done=0; luts, committed copy, ins, sr, n, k, seg all 0.
- Beats per LUT: K*IDX_SEGS + MASK_SEGS (8 at defaults); per sweep N times that (128 at defaults).
- Latency: LUT write lands on the edge accepting its last mask beat; out reflects it the following cycle (in-place mode).
- rst mid-frame: all state cleared on that edge; first accepted beat after deassertion is LUT 0, index 0, segment 0.
- Wrap: after LUT N-1 the next frame is LUT 0 with no gap beats required.

## Configuration
- S4GA_SYNC_EN defined: two-phase mode. Index reads come from a committed copy `cur`; frame writes go to `nxt`; on the edge writing LUT N-1, cur <= nxt (including that write). out = cur[OUT_W-1:0], so out updates only once per sweep, the cycle sweep_done is high.
- Undefined: in-place (Gauss-Seidel) mode, single luts vector, later LUTs in a sweep see earlier LUTs' new values; out = luts[OUT_W-1:0], updating per LUT.

## Test plan
- Reset: rst for 2 cycles with si_valid=1, si=4'hF -> out=0, lut_idx=0, sweep_done=0; next accepted beat counted as LUT 0 index 0.
- Constant one: 16 frames, indices 0, mask 16'hFFFF, si_valid=1 -> after 128 beats out=8'hFF, sweep_done high exactly cycle 129, lut_idx back to 0.
- Stall: same stream with si_valid toggling every cycle -> identical out=8'hFF, sweep_done at cycle 257, no state change on invalid cycles.
- Ring: LUT 0 indices all 15, mask 16'h0001 (NOT); LUT i>0 indices all i-1, mask 16'h8000 (BUF) -> in-place: out=8'hFF after sweep 1, 8'h00 after sweep 2; S4GA_SYNC_EN: out=8'h01, 8'h03, 8'h07 at sweeps 1..3.
- Out-of-range: N=13 instance, LUT 0 indices all 15, mask 16'h0001 -> LUT 0 = 1 (input reads 0).
- Mid-frame reset: rst after 5 beats of LUT 3 -> out=0, lut_idx=0; one full clean sweep then gives the constant-one result.
